// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips32_pkg;

  localparam int WORD_SIZE = 32;

  // All-zero word is the MIPS32 nop (sll $0,$0,0); unwritten fetches return it.
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted stream bytes into little-endian 32-bit words, zero-padding on the last byte.
// Latency: 0 cycles; the completed word and its valid pulse are combinational with the accepting byte.
// Backpressure: none of its own; the caller only presents accepted bytes.
//
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset (discards any partial word)
//   i_byte_vld         : a byte is accepted this cycle
//   i_byte_dat         : accepted byte
//   i_byte_last        : accepted byte is the final one of the stream
//   o_word_vld         : a word completes this cycle (4th byte or last byte)
//   o_word_dat         : completed word, upper bytes zero when padded
//   o_word_pad         : word completed early by the last byte (padding applied)
module imem_word_packer
  import mips32_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_byte_vld,
  input  logic [7:0]           i_byte_dat,
  input  logic                 i_byte_last,
  output logic                 o_word_vld,
  output logic [WORD_SIZE-1:0] o_word_dat,
  output logic                 o_word_pad
);

  logic [1:0]           r_idx;
  logic [23:0]          r_buf;
  logic [WORD_SIZE-1:0] w_word;
  logic                 w_word_end;

  // Merge the incoming byte at the current index over the bytes already
  // collected; everything above the index stays zero, which is the padding.
  always_comb begin
    w_word = NOP_INSTR;
    case (r_idx)
      2'd0:    w_word = {24'h0, i_byte_dat};
      2'd1:    w_word = {16'h0, i_byte_dat, r_buf[7:0]};
      2'd2:    w_word = {8'h0, i_byte_dat, r_buf[15:0]};
      default: w_word = {i_byte_dat, r_buf};
    endcase
  end

  assign w_word_end = i_byte_vld & ((r_idx == 2'd3) | i_byte_last);

  assign o_word_vld = w_word_end;
  assign o_word_dat = w_word;
  assign o_word_pad = i_byte_vld & i_byte_last & (r_idx != 2'd3);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_idx <= 2'd0;
      r_buf <= 24'h0;
    end else if (w_word_end) begin
      // Next accepted byte always starts a fresh word at byte 0.
      r_idx <= 2'd0;
      r_buf <= 24'h0;
    end else if (i_byte_vld) begin
      r_buf <= w_word[23:0];
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-streamed program into instruction memory, holds the core in reset, then runs it.
// Latency: a completed word is written on the accepting edge and fetchable the next cycle; fetch is combinational.
// Backpressure: in_ready is high in IDLE/LOAD/DONE and low in HOLD/RUN; bytes offered while low are ignored.
//
// Ports:
//   i_clock, i_reset_n : clock, async active-low reset
//   i_in_valid/o_in_ready/i_in_data/i_in_last : byte stream, little-endian word packing
//   i_raddr, o_instr   : core fetch port, word addressed, returns nop beyond the loaded words
//   o_core_reset       : active-high reset to the core
//   i_halted           : core halted, only observed while running
//   o_load_done        : program loaded and core released
//   o_word_count       : words written in the current load (saturates at memory depth)
//   o_error            : sticky: padded final word or overflow in the current load
module imem_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int RESET_HOLD = 7   // must be >= 1
)(
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [7:0]           i_in_data,
  input  logic                 i_in_last,
  input  logic [31:0]          i_raddr,
  output logic [WORD_SIZE-1:0] o_instr,
  output logic                 o_core_reset,
  input  logic                 i_halted,
  output logic                 o_load_done,
  output logic [ADDR_SIZE:0]   o_word_count,
  output logic                 o_error
);

  localparam int                 DEPTH     = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] FULL_CNT  = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam int                 HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

  loader_state_t        r_state;
  logic                 r_in_ready;
  logic                 r_core_reset;
  logic                 r_load_done;
  logic [ADDR_SIZE:0]   r_word_count;
  logic                 r_error;
  logic [HOLD_W-1:0]    r_hold_cnt;

  // Instruction memory; contents deliberately survive reset.
  logic [WORD_SIZE-1:0] r_mem [DEPTH];

  logic                 w_accept;
  logic                 w_word_vld;
  logic [WORD_SIZE-1:0] w_word_dat;
  logic                 w_word_pad;
  logic                 w_restart;
  logic [ADDR_SIZE:0]   w_base_count;
  logic                 w_base_error;
  logic                 w_full;
  logic                 w_mem_we;
  logic [ADDR_SIZE:0]   w_next_count;
  logic                 w_next_error;

  assign w_accept = i_in_valid & r_in_ready;

  imem_word_packer u_packer (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_byte_vld  (w_accept),
    .i_byte_dat  (i_in_data),
    .i_byte_last (i_in_last),
    .o_word_vld  (w_word_vld),
    .o_word_dat  (w_word_dat),
    .o_word_pad  (w_word_pad)
  );

  // A byte accepted in DONE opens a new load: it counts against a cleared
  // word count and error, so a one-byte program still lands in word 0.
  assign w_restart    = (r_state == DONE);
  assign w_base_count = w_restart ? '0   : r_word_count;
  assign w_base_error = w_restart ? 1'b0 : r_error;

  // Once every word slot is used, further completed words are dropped.
  assign w_full   = (w_base_count == FULL_CNT);
  assign w_mem_we = w_word_vld & ~w_full;

  assign w_next_count = w_mem_we ? (w_base_count + 1'b1) : w_base_count;
  assign w_next_error = w_base_error | w_word_pad | (w_word_vld & w_full);

  always_ff @(posedge i_clock) begin
    if (w_mem_we) begin
      r_mem[w_base_count[ADDR_SIZE-1:0]] <= w_word_dat;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b1;
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_word_count <= '0;
      r_error      <= 1'b0;
      r_hold_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE, LOAD, DONE: begin
          if (w_accept) begin
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_word_count <= w_next_count;
            r_error      <= w_next_error;
            if (i_in_last) begin
              r_state    <= HOLD;
              r_in_ready <= 1'b0;
              r_hold_cnt <= '0;
            end else begin
              r_state <= LOAD;
            end
          end
        end

        // Counter starts on the edge that accepted the last byte, so the
        // core sees exactly RESET_HOLD more cycles of reset.
        HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state      <= RUN;
            r_core_reset <= 1'b0;
            r_load_done  <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        RUN: begin
          if (i_halted) begin
            r_state    <= DONE;
            r_in_ready <= 1'b1;
          end
        end

        default: begin
          r_state      <= IDLE;
          r_in_ready   <= 1'b1;
          r_core_reset <= 1'b1;
          r_load_done  <= 1'b0;
        end
      endcase
    end
  end

  // Word count never exceeds DEPTH, so an in-range compare also keeps the
  // truncated index inside the array.
  always_comb begin
    o_instr = NOP_INSTR;
    if (i_raddr < 32'(r_word_count)) begin
      o_instr = r_mem[i_raddr[ADDR_SIZE-1:0]];
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_core_reset = r_core_reset;
  assign o_load_done  = r_load_done;
  assign o_word_count = r_word_count;
  assign o_error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT A: default 256-word memory
  logic        a_vld, a_rdy, a_last, a_core_reset, a_halted, a_load_done, a_error;
  logic [7:0]  a_dat;
  logic [31:0] a_raddr, a_instr;
  logic [8:0]  a_count;

  // DUT B: 4-word memory for overflow
  logic        b_vld, b_rdy, b_last, b_core_reset, b_halted, b_load_done, b_error;
  logic [7:0]  b_dat;
  logic [31:0] b_raddr, b_instr;
  logic [2:0]  b_count;

  int tests = 0;
  int fails = 0;

  imem_loader u_dut_a (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_in_valid(a_vld), .o_in_ready(a_rdy), .i_in_data(a_dat), .i_in_last(a_last),
    .i_raddr(a_raddr), .o_instr(a_instr),
    .o_core_reset(a_core_reset), .i_halted(a_halted),
    .o_load_done(a_load_done), .o_word_count(a_count), .o_error(a_error)
  );

  imem_loader #(.ADDR_SIZE(2), .RESET_HOLD(7)) u_dut_b (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_in_valid(b_vld), .o_in_ready(b_rdy), .i_in_data(b_dat), .i_in_last(b_last),
    .i_raddr(b_raddr), .o_instr(b_instr),
    .o_core_reset(b_core_reset), .i_halted(b_halted),
    .o_load_done(b_load_done), .o_word_count(b_count), .o_error(b_error)
  );

  typedef struct {
    logic [31:0] raddr;
    logic [31:0] instr;
  } fvec_t;

  fvec_t      fa [7];
  fvec_t      fb [5];
  logic [7:0] s1 [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input logic last);
    @(negedge clk);
    if (!sel) begin a_vld = 1'b1; a_dat = d; a_last = last; end
    else      begin b_vld = 1'b1; b_dat = d; b_last = last; end
    check("in_ready on send", sel ? b_rdy : a_rdy, 1);
    @(posedge clk); #1;
    a_vld = 1'b0; a_last = 1'b0;
    b_vld = 1'b0; b_last = 1'b0;
  endtask

  task automatic fetch_a(input string name, input logic [31:0] addr, input logic [31:0] exp);
    a_raddr = addr;
    #1;
    check(name, a_instr, exp);
  endtask

  task automatic wait_run(input bit sel);
    for (int i = 0; i < 20; i++) begin
      if ((sel ? b_load_done : a_load_done) === 1'b1) break;
      @(posedge clk); #1;
    end
    check("reached RUN", sel ? b_load_done : a_load_done, 1);
  endtask

  task automatic halt_a();
    a_halted = 1'b1;
    @(posedge clk); #1;
    a_halted = 1'b0;
    check("DONE load_done", a_load_done, 1);
    check("DONE core_reset", a_core_reset, 0);
    check("DONE in_ready", a_rdy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    fa[0] = '{32'd0,          32'h12345678};
    fa[1] = '{32'd1,          32'hDEADBEEF};
    fa[2] = '{32'd2,          32'h00000000};
    fa[3] = '{32'd255,        32'h00000000};
    fa[4] = '{32'd256,        32'h00000000};
    fa[5] = '{32'hFFFFFFFF,   32'h00000000};
    fa[6] = '{32'h00000101,   32'h00000000};
    fb[0] = '{32'd0, 32'h40302010};
    fb[1] = '{32'd1, 32'h41312111};
    fb[2] = '{32'd2, 32'h42322212};
    fb[3] = '{32'd3, 32'h43332313};
    fb[4] = '{32'd4, 32'h00000000};
    s1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    rst_n = 1'b0;
    a_vld = 0; a_last = 0; a_dat = 0; a_raddr = 0; a_halted = 0;
    b_vld = 0; b_last = 0; b_dat = 0; b_raddr = 0; b_halted = 0;
    #12;
    check("reset core_reset", a_core_reset, 1);
    check("reset in_ready", a_rdy, 1);
    check("reset load_done", a_load_done, 0);
    check("reset error", a_error, 0);
    check("reset word_count", a_count, 0);
    check("reset instr", a_instr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load 1: two full words, HOLD timing, ignored bytes in HOLD/RUN
    for (int i = 0; i < 7; i++) begin
      send(0, s1[i], 1'b0);
      if (i == 3) begin
        check("count after word0", a_count, 1);
        fetch_a("word0 visible", 0, 32'h12345678);
      end
    end
    send(0, s1[7], 1'b1);
    check("hold T+1 core_reset", a_core_reset, 1);
    check("hold in_ready", a_rdy, 0);
    check("count after last", a_count, 2);
    a_vld = 1'b1; a_dat = 8'hFF; a_last = 1'b1;
    for (int i = 2; i <= 7; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold T+%0d core_reset", i), a_core_reset, 1);
      check($sformatf("hold T+%0d load_done", i), a_load_done, 0);
    end
    @(posedge clk); #1;
    check("T+8 core_reset", a_core_reset, 0);
    check("T+8 load_done", a_load_done, 1);
    check("RUN in_ready", a_rdy, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_vld = 1'b0; a_last = 1'b0;
    check("ignored bytes count", a_count, 2);
    check("ignored bytes error", a_error, 0);
    check("still running", a_load_done, 1);
    for (int i = 0; i < 7; i++) begin
      a_raddr = fa[i].raddr;
      #1;
      check($sformatf("fetch vec %0d", i), a_instr, fa[i].instr);
    end
    halt_a();

    // Load 2: padded final word
    send(0, 8'h11, 1'b0);
    check("restart core_reset", a_core_reset, 1);
    check("restart load_done", a_load_done, 0);
    check("restart count", a_count, 0);
    send(0, 8'h22, 1'b0);
    send(0, 8'h33, 1'b0);
    send(0, 8'h44, 1'b0);
    send(0, 8'h55, 1'b1);
    check("pad count", a_count, 2);
    check("pad error", a_error, 1);
    fetch_a("pad word0", 0, 32'h44332211);
    fetch_a("pad word1", 1, 32'h00000055);
    fetch_a("pad word2", 2, 32'h00000000);
    wait_run(0);
    halt_a();
    check("error sticky in DONE", a_error, 1);

    // Load 3: restart from DONE clears error
    send(0, 8'h0D, 1'b0);
    check("restart error cleared", a_error, 0);
    check("restart count 0", a_count, 0);
    send(0, 8'h00, 1'b0);
    send(0, 8'h00, 1'b0);
    send(0, 8'h00, 1'b1);
    check("load3 count", a_count, 1);
    check("load3 error", a_error, 0);
    fetch_a("load3 word0", 0, 32'h0000000D);
    fetch_a("load3 stale word1", 1, 32'h00000000);
    wait_run(0);
    halt_a();

    // Load 4: async reset mid-word, next load starts at byte 0 word 0
    send(0, 8'h01, 1'b0);
    send(0, 8'h02, 1'b0);
    send(0, 8'h03, 1'b0);
    send(0, 8'h04, 1'b0);
    send(0, 8'hAA, 1'b0);
    send(0, 8'hBB, 1'b0);
    check("pre-reset count", a_count, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async core_reset", a_core_reset, 1);
    check("async in_ready", a_rdy, 1);
    check("async count", a_count, 0);
    check("async load_done", a_load_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) send(0, 8'(i), i == 8);
    check("after reset count", a_count, 2);
    check("after reset error", a_error, 0);
    fetch_a("after reset word0", 0, 32'h04030201);
    fetch_a("after reset word1", 1, 32'h08070605);
    wait_run(0);

    // DUT B: five words into a four-word memory
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        send(1, 8'((j + 1) * 16 + k), (k == 4) && (j == 3));
      end
      if (k == 3) begin
        check("B full count", b_count, 4);
        check("B full error", b_error, 0);
      end
    end
    check("B overflow count", b_count, 4);
    check("B overflow error", b_error, 1);
    for (int i = 0; i < 5; i++) begin
      b_raddr = fb[i].raddr;
      #1;
      check($sformatf("B fetch vec %0d", i), b_instr, fb[i].instr);
    end
    wait_run(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
